// File: rtl/bus_slave_resp.sv
// Bus slave with a small byte-writable register window.
// Each transaction is answered with a one-cycle rdy_o strobe after a fixed number of wait states.
module bus_slave_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFC0,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        addr_strobe_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  output logic [31:0] rd_data_o,
  output logic        rdy_o,
  output logic        busy_o
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx_p0;
  logic               we_p0;
  logic [3:0]         sel_p0;
  logic [31:0]        wdata_p0;
  logic [31:0]        mem [DEPTH];
  logic               hit;
  logic               accept;

  assign hit    = (addr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  assign accept = (state == IDLE) && addr_strobe_i && hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt <= 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request capture at accept; storage commit at the edge that ends RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_p0   <= '0;
      we_p0    <= 1'b0;
      sel_p0   <= '0;
      wdata_p0 <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= WAIT_LD;
        idx_p0   <= addr_i[2 +: IDX_W];
        we_p0    <= we_i;
        sel_p0   <= sel_i;
        wdata_p0 <= wr_data_i;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP && we_p0) begin
        for (int b = 0; b < 4; b++)
          if (sel_p0[b]) mem[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
      end
    end
  end

  assign rdy_o     = (state == RESP);
  assign busy_o    = (state != IDLE);
  assign rd_data_o = (state == RESP && !we_p0) ? mem[idx_p0] : 32'h0;

endmodule

// File: tb/tb_bus_slave_resp.sv
// Bench for bus_slave_resp: directed scenarios plus random traffic against a word-array model.
// One instance uses one wait state, a second instance uses zero wait states.
module tb_bus_slave_resp;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FFC0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr1, wdata1, rdata1;
  logic        stb1, we1, rdy1, busy1;
  logic [3:0]  sel1;
  logic [31:0] addr0, wdata0, rdata0;
  logic        stb0, we0, rdy0, busy0;
  logic [3:0]  sel0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [16];
  logic [31:0] rd;

  always #5 clk = ~clk;

  bus_slave_resp #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .DEPTH(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .addr_i(addr1), .wr_data_i(wdata1), .addr_strobe_i(stb1),
    .sel_i(sel1), .we_i(we1), .rd_data_o(rdata1), .rdy_o(rdy1), .busy_o(busy1));

  bus_slave_resp #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .addr_i(addr0), .wr_data_i(wdata0), .addr_strobe_i(stb0),
    .sel_i(sel0), .we_i(we0), .rd_data_o(rdata0), .rdy_o(rdy0), .busy_o(busy0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  // One transaction on the one-wait-state instance; rd returns the data seen with rdy_o.
  task automatic txn1(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input string tag, output logic [31:0] rd_out);
    logic        hit;
    logic        stray;
    logic [31:0] exp;
    int          lat;
    hit   = ((a & MASK) == (BASE & MASK));
    exp   = w ? 32'h0 : model[a[5:2]];
    stray = 1'b0;
    rd_out = 32'h0;
    @(negedge clk);
    addr1 = a; we1 = w; sel1 = s; wdata1 = d; stb1 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0; addr1 = $urandom; wdata1 = $urandom; sel1 = 4'($urandom); we1 = 1'($urandom);
    lat = 1;
    if (hit) begin
      while (!rdy1 && lat < 16) begin
        if (rdata1 !== 32'h0 || !busy1) stray = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
      rd_out = rdata1;
      chk({tag, " latency"}, 32'(lat), 32'd2);
      chk({tag, " data"}, rdata1, exp);
      chk({tag, " busy_resp"}, {31'b0, busy1}, 32'd1);
      chk({tag, " wait_outputs"}, {31'b0, stray}, 32'd0);
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
      @(posedge clk); #1;
      chk({tag, " idle_after"}, {rdy1, busy1, rdata1}, 34'h0);
    end else begin
      repeat (4) begin
        if (rdy1 || busy1 || rdata1 !== 32'h0) stray = 1'b1;
        @(posedge clk); #1;
      end
      chk({tag, " miss_quiet"}, {31'b0, stray}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic        w;
    logic [3:0]  s;
    rst = 1'b1;
    addr1 = 0; wdata1 = 0; stb1 = 0; we1 = 0; sel1 = 0;
    addr0 = 0; wdata0 = 0; stb0 = 0; we0 = 0; sel0 = 0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("reset dut1", {rdy1, busy1, rdata1}, 34'h0);
    chk("reset dut0", {rdy0, busy0, rdata0}, 34'h0);

    txn1(32'h08, 1'b1, 4'hF, 32'hDEADBEEF, "wr08", rd);
    txn1(32'h08, 1'b0, 4'hF, 32'h0, "rd08", rd);
    chk("rd08 const", rd, 32'hDEADBEEF);

    txn1(32'h08, 1'b1, 4'b0101, 32'h11223344, "wr08_sel", rd);
    txn1(32'h08, 1'b0, 4'h0, 32'h0, "rd08_sel", rd);
    chk("byte_merge const", rd, 32'hDE22BE44);

    txn1(32'h04, 1'b1, 4'hF, 32'h12345678, "wr04", rd);
    txn1(32'h04, 1'b1, 4'h0, 32'hFFFFFFFF, "wr04_sel0", rd);
    txn1(32'h04, 1'b0, 4'hF, 32'h0, "rd04", rd);
    chk("sel0 const", rd, 32'h12345678);

    txn1(BASE + 32'h40, 1'b1, 4'hF, 32'hCAFEF00D, "miss40", rd);
    txn1(32'h08, 1'b0, 4'hF, 32'h0, "rd08_after_miss", rd);
    chk("miss keeps 08", rd, 32'hDE22BE44);
    txn1(32'h00, 1'b0, 4'hF, 32'h0, "rd00_after_miss", rd);
    chk("miss keeps 00", rd, 32'h0);

    // strobe during reset is ignored; reset clears storage
    @(negedge clk);
    rst = 1'b1; addr1 = 32'h08; we1 = 1'b0; stb1 = 1'b1;
    @(posedge clk); #1;
    chk("strobe_in_reset", {rdy1, busy1}, 2'b00);
    @(negedge clk);
    stb1 = 1'b0; rst = 1'b0;
    clear_model();
    txn1(32'h08, 1'b0, 4'hF, 32'h0, "rd08_after_reset", rd);
    chk("reset clears 08", rd, 32'h0);

    // reset in WAIT aborts a pending write
    txn1(32'h0C, 1'b1, 4'hF, 32'hAAAA5555, "wr0C", rd);
    @(negedge clk);
    addr1 = 32'h0C; we1 = 1'b1; sel1 = 4'hF; wdata1 = 32'h0BADF00D; stb1 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0;
    chk("abort busy_in_wait", {31'b0, busy1}, 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort outputs", {rdy1, busy1}, 2'b00);
    @(negedge clk) rst = 1'b0;
    clear_model();
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no_rdy", {rdy1, busy1}, 2'b00);
    end
    txn1(32'h0C, 1'b0, 4'hF, 32'h0, "rd0C_after_abort", rd);
    chk("abort const", rd, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) a = $urandom | 32'h0000_0100;
      else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      w = 1'($urandom);
      s = 4'($urandom);
      d = $urandom;
      txn1(a, w, s, d, $sformatf("rnd%0d", n), rd);
    end

    // zero wait states, strobe held: one response every second cycle
    @(negedge clk);
    addr0 = 32'h00; we0 = 1'b0; sel0 = 4'hF; stb0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b rdy k%0d", k), {31'b0, rdy0}, 32'(k % 2));
      chk($sformatf("b2b busy k%0d", k), {31'b0, busy0}, 32'(k % 2));
      chk($sformatf("b2b data k%0d", k), rdata0, 32'h0);
    end
    @(negedge clk) stb0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
